// File: rtl/mult12_pkg.sv
// Shared types and constants for the 12x12 sequential multiplier.
// The multiplier is built from one 6x6 multiplier reused over four cycles.
package mult12_pkg;

  localparam int IN_W   = 12;
  localparam int HALF_W = 6;
  localparam int PROD_W = 24;
  localparam int STEP_W = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Place a 12-bit partial product at its weight.
  // Step 0 has weight 2^0, steps 1 and 2 have 2^6, and step 3 has 2^12.
  function automatic logic [PROD_W-1:0] place_partial(
    input logic [2*HALF_W-1:0] pp,
    input logic [STEP_W-1:0]   step
  );
    logic [PROD_W-1:0] wide;
    wide = {{(PROD_W-2*HALF_W){1'b0}}, pp};
    case (step)
      2'd0:    place_partial = wide;
      2'd3:    place_partial = wide << (2*HALF_W);
      default: place_partial = wide << HALF_W;
    endcase
  endfunction

endpackage

// File: rtl/mult12_sequencer_six_bit_multiplier.sv
// Combinational 6x6 unsigned multiplier.
// The sequencer time-multiplexes this single instance over all four partial products.
module six_bit_multiplier
  import mult12_pkg::*;
(
  input  logic [HALF_W-1:0]   a_i,
  input  logic [HALF_W-1:0]   b_i,
  output logic [2*HALF_W-1:0] p_o
);

  assign p_o = {{HALF_W{1'b0}}, a_i} * {{HALF_W{1'b0}}, b_i};

endmodule

// File: rtl/mult12_sequencer.sv
// 12x12 unsigned multiplier with a valid/ready interface.
// It computes four 6x6 partial products over four cycles, then holds the result in DONE.
module mult12_sequencer #(
  parameter int IN_W = mult12_pkg::IN_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [IN_W-1:0] a,
  input  logic [IN_W-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [2*IN_W-1:0] c,
  output logic            busy
);
  import mult12_pkg::*;

  if (IN_W != mult12_pkg::IN_W) begin : g_width_check
    $error("mult12_sequencer supports IN_W=12 only");
  end

  state_t              state_q, state_d;
  logic [STEP_W-1:0]   step_q, step_d;
  logic [IN_W-1:0]     a_q, a_d;
  logic [IN_W-1:0]     b_q, b_d;
  logic [PROD_W-1:0]   acc_q, acc_d;
  logic                out_valid_q, out_valid_d;
  logic [HALF_W-1:0]   mul_a, mul_b;
  logic [2*HALF_W-1:0] mul_p;
  logic                accept;

  // Step bit 1 selects the high half of a, and step bit 0 selects the high half of b.
  assign mul_a = step_q[1] ? a_q[2*HALF_W-1:HALF_W] : a_q[HALF_W-1:0];
  assign mul_b = step_q[0] ? b_q[2*HALF_W-1:HALF_W] : b_q[HALF_W-1:0];

  six_bit_multiplier u_mul (
    .a_i (mul_a),
    .b_i (mul_b),
    .p_o (mul_p)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      step_q      <= '0;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      a_q         <= a_d;
      b_q         <= b_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = MUL;
      MUL:     if (step_q == STEP_W'(3)) state_d = DONE;
      DONE:    if (out_ready) state_d = in_valid ? MUL : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready = !rst && ((state_q == IDLE) || ((state_q == DONE) && out_ready));
    busy     = (state_q != IDLE);
  end

  assign accept = in_valid && in_ready;

  always_comb begin
    step_d = step_q;
    a_d    = a_q;
    b_d    = b_q;
    acc_d  = acc_q;
    if (accept) begin
      a_d    = a;
      b_d    = b;
      acc_d  = '0;
      step_d = '0;
    end else if (state_q == MUL) begin
      acc_d  = acc_q + place_partial(mul_p, step_q);
      step_d = step_q + STEP_W'(1);
    end
    out_valid_d = (state_d == DONE);
  end

  assign out_valid = out_valid_q;
  assign c         = acc_q;

endmodule
